// File: rtl/if_stage.sv
// Instruction-fetch stage slot: holds one fetched PC, buffers its inst-RAM response and
// discards responses belonging to flushed requests. Optional stall counter under IF_PERF_CNT_EN.
module if_stage #(
    parameter int PC_W    = 32,
    parameter int ETYPE_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               excep_flush_i,
    input  logic               preif_valid_i,
    input  logic               preif_req_i,
    input  logic [PC_W-1:0]    preif_pc_i,
    input  logic               preif_excep_en_i,
    input  logic [ETYPE_W-1:0] preif_excep_type_i,
    output logic               now_allowin_o,
    input  logic               inst_data_ok_i,
    input  logic [PC_W-1:0]    inst_rdata_i,
    input  logic               next_allowin_i,
    output logic               now_to_next_valid_o,
    output logic [PC_W-1:0]    to_next_pc_o,
    output logic [PC_W-1:0]    to_next_inst_o,
    output logic               to_next_excep_en_o,
    output logic [ETYPE_W-1:0] to_next_excep_type_o,
    output logic               to_preif_we_o,
    output logic [PC_W-1:0]    to_preif_pc_o,
    output logic [31:0]        perf_if_stall_cnt_o
);

    localparam logic [PC_W-1:0] EXC_INST = PC_W'(32'h0340_0000);

    logic               valid_q, valid_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               req_q, req_d;
    logic               exc_en_q, exc_en_d;
    logic [ETYPE_W-1:0] exc_type_q, exc_type_d;
    logic [PC_W-1:0]    buf_q, buf_d;
    logic               buf_vld_q, buf_vld_d;
    logic [1:0]         cancel_cnt_q, cancel_cnt_d;

    logic data_ok_live;
    logic ready_go;
    logic leave;
    logic load;
    logic cancel_inc;
    logic cancel_dec;

    // A response only belongs to the current slot once all cancelled ones have drained.
    assign data_ok_live = inst_data_ok_i & (cancel_cnt_q == 2'd0);
    assign ready_go     = valid_q & (exc_en_q | buf_vld_q | data_ok_live);
    assign leave        = ready_go & next_allowin_i;
    assign load         = preif_valid_i & now_allowin_o & ~excep_flush_i;
    assign cancel_inc   = excep_flush_i & valid_q & req_q & ~buf_vld_q & ~data_ok_live;
    assign cancel_dec   = inst_data_ok_i & (cancel_cnt_q != 2'd0);

    assign now_allowin_o        = ~valid_q | leave;
    assign now_to_next_valid_o  = valid_q & ready_go & ~excep_flush_i;
    assign to_next_pc_o         = pc_q;
    assign to_next_excep_en_o   = exc_en_q;
    assign to_next_excep_type_o = exc_type_q;
    assign to_preif_we_o        = valid_q;
    assign to_preif_pc_o        = pc_q;

    always_comb begin
        to_next_inst_o = inst_rdata_i;
        if (exc_en_q) begin
            to_next_inst_o = EXC_INST;
        end else if (buf_vld_q) begin
            to_next_inst_o = buf_q;
        end
    end

    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        req_d      = req_q;
        exc_en_d   = exc_en_q;
        exc_type_d = exc_type_q;
        buf_d      = buf_q;
        buf_vld_d  = buf_vld_q;

        if (data_ok_live & valid_q & req_q & ~buf_vld_q & ~leave) begin
            buf_d     = inst_rdata_i;
            buf_vld_d = 1'b1;
        end

        if (excep_flush_i) begin
            valid_d   = 1'b0;
            buf_vld_d = 1'b0;
        end else if (load) begin
            valid_d    = 1'b1;
            pc_d       = preif_pc_i;
            req_d      = preif_req_i;
            exc_en_d   = preif_excep_en_i;
            exc_type_d = preif_excep_type_i;
            buf_vld_d  = 1'b0;
        end else if (leave) begin
            valid_d = 1'b0;
        end
    end

    always_comb begin
        cancel_cnt_d = cancel_cnt_q;
        if (cancel_inc & ~cancel_dec) begin
            if (cancel_cnt_q != 2'd3) begin
                cancel_cnt_d = cancel_cnt_q + 2'd1;
            end
        end else if (cancel_dec & ~cancel_inc) begin
            cancel_cnt_d = cancel_cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= 1'b0;
            pc_q         <= '0;
            req_q        <= 1'b0;
            exc_en_q     <= 1'b0;
            exc_type_q   <= '0;
            buf_q        <= '0;
            buf_vld_q    <= 1'b0;
            cancel_cnt_q <= 2'd0;
        end else begin
            valid_q      <= valid_d;
            pc_q         <= pc_d;
            req_q        <= req_d;
            exc_en_q     <= exc_en_d;
            exc_type_q   <= exc_type_d;
            buf_q        <= buf_d;
            buf_vld_q    <= buf_vld_d;
            cancel_cnt_q <= cancel_cnt_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_cnt_q, perf_cnt_d;

    always_comb begin
        perf_cnt_d = perf_cnt_q;
        if (valid_q & ~ready_go) begin
            perf_cnt_d = perf_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cnt_q <= 32'd0;
        end else begin
            perf_cnt_q <= perf_cnt_d;
        end
    end

    assign perf_if_stall_cnt_o = perf_cnt_q;
`else
    assign perf_if_stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus a randomized run against an
// outstanding-request queue model.
module tb_if_stage;
    localparam int PC_W    = 32;
    localparam int ETYPE_W = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               excep_flush_i;
    logic               preif_valid_i;
    logic               preif_req_i;
    logic [PC_W-1:0]    preif_pc_i;
    logic               preif_excep_en_i;
    logic [ETYPE_W-1:0] preif_excep_type_i;
    logic               now_allowin_o;
    logic               inst_data_ok_i;
    logic [PC_W-1:0]    inst_rdata_i;
    logic               next_allowin_i;
    logic               now_to_next_valid_o;
    logic [PC_W-1:0]    to_next_pc_o;
    logic [PC_W-1:0]    to_next_inst_o;
    logic               to_next_excep_en_o;
    logic [ETYPE_W-1:0] to_next_excep_type_o;
    logic               to_preif_we_o;
    logic [PC_W-1:0]    to_preif_pc_o;
    logic [31:0]        perf_if_stall_cnt_o;

    int checks   = 0;
    int failures = 0;

    if_stage #(.PC_W(PC_W), .ETYPE_W(ETYPE_W)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .excep_flush_i        (excep_flush_i),
        .preif_valid_i        (preif_valid_i),
        .preif_req_i          (preif_req_i),
        .preif_pc_i           (preif_pc_i),
        .preif_excep_en_i     (preif_excep_en_i),
        .preif_excep_type_i   (preif_excep_type_i),
        .now_allowin_o        (now_allowin_o),
        .inst_data_ok_i       (inst_data_ok_i),
        .inst_rdata_i         (inst_rdata_i),
        .next_allowin_i       (next_allowin_i),
        .now_to_next_valid_o  (now_to_next_valid_o),
        .to_next_pc_o         (to_next_pc_o),
        .to_next_inst_o       (to_next_inst_o),
        .to_next_excep_en_o   (to_next_excep_en_o),
        .to_next_excep_type_o (to_next_excep_type_o),
        .to_preif_we_o        (to_preif_we_o),
        .to_preif_pc_o        (to_preif_pc_o),
        .perf_if_stall_cnt_o  (perf_if_stall_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic idle();
        excep_flush_i      = 1'b0;
        preif_valid_i      = 1'b0;
        preif_req_i        = 1'b0;
        preif_pc_i         = '0;
        preif_excep_en_i   = 1'b0;
        preif_excep_type_i = '0;
        inst_data_ok_i     = 1'b0;
        inst_rdata_i       = '0;
        next_allowin_i     = 1'b1;
    endtask

    // Advance to just after the next rising edge.
    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        clk_step();
        checks++; if (now_allowin_o !== 1'b1) begin failures++; $display("FAIL reset_allowin got=%0b exp=1", now_allowin_o); end
        checks++; if (now_to_next_valid_o !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", now_to_next_valid_o); end
        checks++; if (to_preif_we_o !== 1'b0) begin failures++; $display("FAIL reset_preif_we got=%0b exp=0", to_preif_we_o); end
        checks++; if (perf_if_stall_cnt_o !== 32'd0) begin failures++; $display("FAIL reset_perf got=%0h exp=0", perf_if_stall_cnt_o); end
        rst = 1'b0;
        clk_step();
    endtask

    task automatic test_basic_fetch();
        idle();
        preif_valid_i = 1'b1; preif_req_i = 1'b1; preif_pc_i = 32'h1C00_0000;
        #1;
        checks++; if (now_allowin_o !== 1'b1) begin failures++; $display("FAIL basic_allowin got=%0b exp=1", now_allowin_o); end
        clk_step();
        idle();
        inst_data_ok_i = 1'b1; inst_rdata_i = 32'h0280_0421;
        #1;
        checks++; if (now_to_next_valid_o !== 1'b1) begin failures++; $display("FAIL basic_out_valid got=%0b exp=1", now_to_next_valid_o); end
        checks++; if (to_next_inst_o !== 32'h0280_0421) begin failures++; $display("FAIL basic_inst got=%0h exp=02800421", to_next_inst_o); end
        checks++; if (to_next_pc_o !== 32'h1C00_0000) begin failures++; $display("FAIL basic_pc got=%0h exp=1c000000", to_next_pc_o); end
        checks++; if (to_preif_pc_o !== 32'h1C00_0000 || to_preif_we_o !== 1'b1) begin failures++; $display("FAIL basic_preif got=%0b/%0h exp=1/1c000000", to_preif_we_o, to_preif_pc_o); end
        clk_step();
        idle();
        #1;
        checks++; if (to_preif_we_o !== 1'b0) begin failures++; $display("FAIL basic_empty got=%0b exp=0", to_preif_we_o); end
    endtask

    task automatic test_buffer();
        idle();
        preif_valid_i = 1'b1; preif_req_i = 1'b1; preif_pc_i = 32'h1C00_0004;
        clk_step();
        idle();
        next_allowin_i = 1'b0; inst_data_ok_i = 1'b1; inst_rdata_i = 32'h0000_1234;
        #1;
        checks++; if (now_allowin_o !== 1'b0) begin failures++; $display("FAIL buf_allowin got=%0b exp=0", now_allowin_o); end
        clk_step();
        for (int i = 0; i < 2; i++) begin
            idle();
            next_allowin_i = 1'b0; inst_rdata_i = $urandom | 32'h8000_0000;
            #1;
            checks++; if (dut.buf_vld_q !== 1'b1) begin failures++; $display("FAIL buf_vld got=%0b exp=1", dut.buf_vld_q); end
            checks++; if (to_next_inst_o !== 32'h0000_1234) begin failures++; $display("FAIL buf_hold got=%0h exp=1234", to_next_inst_o); end
            clk_step();
        end
        idle();
        inst_rdata_i = 32'hFFFF_0000;
        #1;
        checks++; if (now_to_next_valid_o !== 1'b1 || to_next_inst_o !== 32'h0000_1234) begin failures++; $display("FAIL buf_forward got=%0b/%0h exp=1/1234", now_to_next_valid_o, to_next_inst_o); end
        checks++; if (now_allowin_o !== 1'b1) begin failures++; $display("FAIL buf_allowin_release got=%0b exp=1", now_allowin_o); end
        clk_step();
    endtask

    task automatic test_cancel();
        idle();
        preif_valid_i = 1'b1; preif_req_i = 1'b1; preif_pc_i = 32'h1C00_0100;
        clk_step();
        idle();
        excep_flush_i = 1'b1;
        clk_step();
        idle();
        #1;
        checks++; if (dut.cancel_cnt_q !== 2'd1) begin failures++; $display("FAIL cancel_cnt got=%0d exp=1", dut.cancel_cnt_q); end
        checks++; if (to_preif_we_o !== 1'b0) begin failures++; $display("FAIL cancel_flushed got=%0b exp=0", to_preif_we_o); end
        preif_valid_i = 1'b1; preif_req_i = 1'b1; preif_pc_i = 32'h1C00_8000;
        clk_step();
        idle();
        inst_data_ok_i = 1'b1; inst_rdata_i = 32'hDEAD_BEEF;
        #1;
        checks++; if (now_to_next_valid_o !== 1'b0) begin failures++; $display("FAIL cancel_stale_used got=%0b exp=0", now_to_next_valid_o); end
        clk_step();
        idle();
        inst_data_ok_i = 1'b1; inst_rdata_i = 32'h1111_0000;
        #1;
        checks++; if (dut.cancel_cnt_q !== 2'd0) begin failures++; $display("FAIL cancel_drain got=%0d exp=0", dut.cancel_cnt_q); end
        checks++; if (now_to_next_valid_o !== 1'b1 || to_next_inst_o !== 32'h1111_0000 || to_next_pc_o !== 32'h1C00_8000) begin
            failures++; $display("FAIL cancel_new_slot got=%0b/%0h/%0h exp=1/11110000/1c008000", now_to_next_valid_o, to_next_inst_o, to_next_pc_o);
        end
        clk_step();
    endtask

    task automatic test_excep();
        idle();
        preif_valid_i = 1'b1; preif_excep_en_i = 1'b1; preif_excep_type_i = 16'h0042; preif_pc_i = 32'h1C00_0200;
        clk_step();
        idle();
        inst_rdata_i = 32'h5555_AAAA;
        #1;
        checks++; if (now_to_next_valid_o !== 1'b1 || to_next_inst_o !== 32'h0340_0000) begin failures++; $display("FAIL excep_out got=%0b/%0h exp=1/03400000", now_to_next_valid_o, to_next_inst_o); end
        checks++; if (to_next_excep_en_o !== 1'b1 || to_next_excep_type_o !== 16'h0042) begin failures++; $display("FAIL excep_type got=%0b/%0h exp=1/42", to_next_excep_en_o, to_next_excep_type_o); end
        clk_step();
    endtask

    task automatic test_reset_mid();
        idle();
        preif_valid_i = 1'b1; preif_req_i = 1'b1; preif_pc_i = 32'h1C00_0300;
        clk_step();
        idle();
        clk_step();
        #2;
        rst = 1'b1;
        #1;
        checks++; if (now_to_next_valid_o !== 1'b0 || to_preif_we_o !== 1'b0 || now_allowin_o !== 1'b1) begin
            failures++; $display("FAIL rst_mid_outputs got=%0b/%0b/%0b exp=0/0/1", now_to_next_valid_o, to_preif_we_o, now_allowin_o);
        end
        checks++; if (to_preif_pc_o !== 32'd0) begin failures++; $display("FAIL rst_mid_pc got=%0h exp=0", to_preif_pc_o); end
        clk_step();
        rst = 1'b0;
        inst_data_ok_i = 1'b1; inst_rdata_i = 32'h7777_7777;
        #1;
        checks++; if (now_to_next_valid_o !== 1'b0) begin failures++; $display("FAIL rst_stale_fwd got=%0b exp=0", now_to_next_valid_o); end
        clk_step();
        idle();
        #1;
        checks++; if (dut.buf_vld_q !== 1'b0 || to_preif_we_o !== 1'b0) begin failures++; $display("FAIL rst_stale_consumed got=%0b/%0b exp=0/0", dut.buf_vld_q, to_preif_we_o); end
        clk_step();
    endtask

    task automatic test_perf();
        logic [31:0] p0;
        idle();
        preif_valid_i = 1'b1; preif_req_i = 1'b1; preif_pc_i = 32'h1C00_0400;
        clk_step();
        idle();
        #1;
        p0 = perf_if_stall_cnt_o;
        for (int i = 0; i < 5; i++) clk_step();
        inst_data_ok_i = 1'b1; inst_rdata_i = 32'h0000_0001;
        #1;
`ifdef IF_PERF_CNT_EN
        checks++; if (perf_if_stall_cnt_o !== p0 + 32'd5) begin failures++; $display("FAIL perf_delta got=%0d exp=%0d", perf_if_stall_cnt_o, p0 + 32'd5); end
`else
        checks++; if (perf_if_stall_cnt_o !== 32'd0) begin failures++; $display("FAIL perf_off got=%0d exp=0", perf_if_stall_cnt_o); end
`endif
        clk_step();
    endtask

    task automatic test_random();
        bit          q[$];
        bit          m_valid, m_exc, m_has, front_live, m_ready, leave, load, f;
        bit          e_allowin, e_ov;
        logic [31:0] m_pc, m_data, e_inst, e_perf;
        logic [15:0] m_et;
        int unsigned m_perf;
        int          orphans;
        rst = 1'b1;
        idle();
        clk_step();
        rst = 1'b0;
        m_valid = 0; m_exc = 0; m_has = 0; m_pc = 0; m_data = 0; m_et = 0; m_perf = 0;
        q.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            orphans = 0;
            foreach (q[i]) if (!q[i]) orphans++;
            excep_flush_i      = (orphans < 3) && ($urandom_range(0, 11) == 0);
            preif_valid_i      = ($urandom_range(0, 9) < 6);
            preif_excep_en_i   = ($urandom_range(0, 7) == 0);
            preif_req_i        = ~preif_excep_en_i;
            preif_pc_i         = $urandom;
            preif_excep_type_i = 16'($urandom);
            inst_data_ok_i     = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            inst_rdata_i       = $urandom;
            next_allowin_i     = ($urandom_range(0, 9) < 7);

            front_live = inst_data_ok_i && (q.size() > 0) && q[0];
            m_ready    = m_valid && (m_exc || m_has || front_live);
            e_allowin  = !m_valid || (m_ready && next_allowin_i);
            e_ov       = m_valid && m_ready && !excep_flush_i;
            e_inst     = m_exc ? 32'h0340_0000 : (m_has ? m_data : inst_rdata_i);
`ifdef IF_PERF_CNT_EN
            e_perf = m_perf;
`else
            e_perf = 32'd0;
`endif
            #1;
            checks++; if (now_allowin_o !== e_allowin) begin failures++; $display("FAIL rnd_allowin cyc=%0d got=%0b exp=%0b", cyc, now_allowin_o, e_allowin); end
            checks++; if (now_to_next_valid_o !== e_ov) begin failures++; $display("FAIL rnd_out_valid cyc=%0d got=%0b exp=%0b", cyc, now_to_next_valid_o, e_ov); end
            checks++; if (to_preif_we_o !== m_valid) begin failures++; $display("FAIL rnd_preif_we cyc=%0d got=%0b exp=%0b", cyc, to_preif_we_o, m_valid); end
            checks++; if (perf_if_stall_cnt_o !== e_perf) begin failures++; $display("FAIL rnd_perf cyc=%0d got=%0d exp=%0d", cyc, perf_if_stall_cnt_o, e_perf); end
            if (m_valid) begin
                checks++; if (to_next_pc_o !== m_pc || to_preif_pc_o !== m_pc) begin failures++; $display("FAIL rnd_pc cyc=%0d got=%0h/%0h exp=%0h", cyc, to_next_pc_o, to_preif_pc_o, m_pc); end
            end
            if (e_ov) begin
                checks++; if (to_next_inst_o !== e_inst) begin failures++; $display("FAIL rnd_inst cyc=%0d got=%0h exp=%0h", cyc, to_next_inst_o, e_inst); end
                checks++; if (to_next_excep_en_o !== m_exc || to_next_excep_type_o !== m_et) begin
                    failures++; $display("FAIL rnd_excep cyc=%0d got=%0b/%0h exp=%0b/%0h", cyc, to_next_excep_en_o, to_next_excep_type_o, m_exc, m_et);
                end
            end

            leave = m_ready && next_allowin_i;
            load  = preif_valid_i && e_allowin && !excep_flush_i;
            if (inst_data_ok_i) begin
                f = q.pop_front();
                if (f && m_valid && !m_has && !leave) begin
                    m_has  = 1;
                    m_data = inst_rdata_i;
                end
            end
            if (m_valid && !m_ready) m_perf++;
            if (excep_flush_i) begin
                foreach (q[i]) q[i] = 1'b0;
                m_valid = 0;
                m_has   = 0;
            end else if (load) begin
                m_valid = 1;
                m_pc    = preif_pc_i;
                m_exc   = preif_excep_en_i;
                m_et    = preif_excep_type_i;
                m_has   = 0;
                if (preif_req_i) q.push_back(1'b1);
            end else if (leave) begin
                m_valid = 0;
            end
            clk_step();
        end
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_basic_fetch();
        test_buffer();
        test_cancel();
        test_excep();
        test_reset_mid();
        test_perf();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
